// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage definitions (default widths, opcodes, predictor counter type).
package cpu_pkg;
    localparam int DEF_PC_W    = 16;
    localparam int DEF_INSTR_W = 18;
    localparam int DEF_GHR_W   = 3;
    localparam logic [5:0] OP_JMP = 6'h30;
    localparam logic [5:0] OP_BEQ = 6'h31;
    localparam logic [5:0] OP_BNE = 6'h32;
    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_RESET = 2'b01;
endpackage

// File: rtl/gshare_pht.sv
// gshare_pht: table of 2-bit saturating counters, one combinational read port and one update port.
// Ports: clk, reset (sync, active-high); rd_index -> rd_taken (counter MSB);
//        upd_valid/upd_index/upd_taken train one counter per cycle.
// A read that shares an index with a same-cycle update returns the old counter.
module gshare_pht
    import cpu_pkg::*;
#(
    parameter int IDX_W = DEF_GHR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken
);
    ctr_t tbl [2**IDX_W];
    ctr_t cur;

    assign rd_taken = tbl[rd_index][1];
    assign cur      = tbl[upd_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= CTR_RESET;
        end else if (upd_valid) begin
            tbl[upd_index] <= upd_taken ? (cur == 2'd3 ? cur : cur + 2'd1)
                                        : (cur == 2'd0 ? cur : cur - 2'd1);
        end
    end
endmodule

// File: rtl/fetch_gshare_unit.sv
// fetch_gshare_unit: fetch stage with PC, instruction memory read and 2-bit-counter next-PC prediction.
// Ports: clk, reset (sync, active-high), Dstall holds the PC;
//        imem_addr/imem_data combinational instruction read;
//        upd_* branch resolution from execute (trains predictor, redirects on mispredict);
//        Finstruction, Finstruction_increment, Fpc, xorout, Fpredict_taken, Fflush to the F/D register.
// Macro GSHARE_EN: index = PC ^ global history; undefined gives a bimodal PC-indexed predictor.
module fetch_gshare_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int GHR_W   = DEF_GHR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Dstall,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               upd_valid,
    input  logic [GHR_W-1:0]   upd_index,
    input  logic               upd_taken,
    input  logic               upd_mispredict,
    input  logic [PC_W-1:0]    upd_target,
    output logic [INSTR_W-1:0] Finstruction,
    output logic [PC_W-1:0]    Finstruction_increment,
    output logic [PC_W-1:0]    Fpc,
    output logic [GHR_W-1:0]   xorout,
    output logic               Fpredict_taken,
    output logic               Fflush
);
    logic [PC_W-1:0]  pc, pc_next, br_tgt, jmp_tgt;
    logic [GHR_W-1:0] ghr;
    logic [5:0]       opcode;
    logic             is_jmp, is_br, pht_taken, redirect;

    assign opcode   = imem_data[INSTR_W-1 -: 6];
    assign is_jmp   = opcode == OP_JMP;
    assign is_br    = opcode == OP_BEQ || opcode == OP_BNE;
    assign redirect = upd_valid & upd_mispredict;

    assign Fpc                    = pc;
    assign imem_addr              = pc;
    assign Finstruction           = imem_data;
    assign Finstruction_increment = pc + PC_W'(1);
    assign xorout                 = pc[GHR_W-1:0] ^ ghr;
    assign Fpredict_taken         = is_jmp | (is_br & pht_taken);
    assign Fflush                 = redirect & ~reset;

    // Jumps stay within the current 4K-word page; branch offsets are signed 4-bit.
    assign jmp_tgt = {pc[PC_W-1:12], imem_data[11:0]};
    assign br_tgt  = Finstruction_increment + {{(PC_W-4){imem_data[3]}}, imem_data[3:0]};

    always_comb begin
        pc_next = reset          ? '0 :
                  redirect       ? upd_target :
                  Dstall         ? pc :
                  Fpredict_taken ? (is_jmp ? jmp_tgt : br_tgt) :
                                   Finstruction_increment;
    end

    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

`ifdef GSHARE_EN
    // History shifts only on resolution, never speculatively at fetch.
    always_ff @(posedge clk) begin
        if (reset)          ghr <= '0;
        else if (upd_valid) ghr <= {ghr[GHR_W-2:0], upd_taken};
    end
`else
    assign ghr = '0;
`endif

    gshare_pht #(.IDX_W(GHR_W)) u_pht (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (xorout),
        .rd_taken  (pht_taken),
        .upd_valid (upd_valid),
        .upd_index (upd_index),
        .upd_taken (upd_taken)
    );
endmodule

// File: tb/tb_fetch_gshare_unit.sv
// tb_fetch_gshare_unit: directed plan cases plus random traffic checked against a behavioural model.
module tb_fetch_gshare_unit;
    localparam logic [17:0] NOP = 18'h0;
`ifdef GSHARE_EN
    localparam int GS = 1;
`else
    localparam int GS = 0;
`endif
    localparam int BR_IDX  = GS ? 3 : 0;
    localparam int XOR_EXP = GS ? 2 : 7;

    logic        clk = 0, reset = 1, Dstall = 0;
    logic [15:0] imem_addr, Finstruction_increment, Fpc, upd_target = 0;
    logic [17:0] imem_data = 0, Finstruction;
    logic        upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
    logic [2:0]  upd_index = 0, xorout;
    logic        Fpredict_taken, Fflush;

    int vectors = 0, miscompares = 0;
    int m_pc, m_ghr;
    int m_pht [8];

    fetch_gshare_unit dut (
        .clk(clk), .reset(reset), .Dstall(Dstall), .imem_addr(imem_addr), .imem_data(imem_data),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .upd_target(upd_target),
        .Finstruction(Finstruction), .Finstruction_increment(Finstruction_increment), .Fpc(Fpc),
        .xorout(xorout), .Fpredict_taken(Fpredict_taken), .Fflush(Fflush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_ghr = 0;
        for (int i = 0; i < 8; i++) m_pht[i] = 1;
    endtask

    // One cycle: drive at negedge, check combinational outputs, then advance the model at posedge.
    task automatic step(input logic r, input logic d, input logic [17:0] data, input logic uv,
                        input logic [2:0] ui, input logic ut, input logic um, input logic [15:0] tgt);
        int op, idx, imm, pred, nxt;
        @(negedge clk);
        reset = r; Dstall = d; imem_data = data;
        upd_valid = uv; upd_index = ui; upd_taken = ut; upd_mispredict = um; upd_target = tgt;
        #1;
        op   = int'(data) >> 12;
        idx  = GS ? ((m_pc % 8) ^ m_ghr) : (m_pc % 8);
        imm  = data[3] ? int'(data[3:0]) - 16 : int'(data[3:0]);
        pred = (op == 'h30) ? 1 : ((op == 'h31 || op == 'h32) && m_pht[idx] >= 2) ? 1 : 0;
        nxt  = !pred ? (m_pc + 1) % 65536 :
               (op == 'h30) ? (m_pc / 4096) * 4096 + int'(data) % 4096 :
               (m_pc + 1 + imm + 65536) % 65536;
        chk("Fpc", 32'(Fpc), 32'(m_pc));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("Finstruction", 32'(Finstruction), 32'(data));
        chk("Finc", 32'(Finstruction_increment), 32'((m_pc + 1) % 65536));
        chk("xorout", 32'(xorout), 32'(idx));
        chk("Fpredict_taken", 32'(Fpredict_taken), 32'(pred));
        chk("Fflush", 32'(Fflush), 32'(uv && um && !r));
        @(posedge clk);
        if (r) model_reset();
        else begin
            if (uv && um) m_pc = int'(tgt);
            else if (!d) m_pc = nxt;
            if (uv) begin
                m_pht[ui] = ut ? (m_pht[ui] < 3 ? m_pht[ui] + 1 : 3) : (m_pht[ui] > 0 ? m_pht[ui] - 1 : 0);
                if (GS != 0) m_ghr = ((m_ghr * 2) + int'(ut)) % 8;
            end
        end
    endtask

    task automatic go(input logic [15:0] tgt, input logic ut);
        step(0, 0, NOP, 1, 3'd7, ut, 1, tgt);
    endtask

    initial begin
        logic [17:0] data;
        logic [5:0]  ops [4];
        ops[0] = 6'h30; ops[1] = 6'h31; ops[2] = 6'h32; ops[3] = 6'h00;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        chk("rst_Fpc", 32'(Fpc), 0);
        chk("rst_inc", 32'(Finstruction_increment), 1);
        chk("rst_xorout", 32'(xorout), 0);
        chk("rst_Fflush", 32'(Fflush), 0);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, NOP, 0, 0, 0, 0, 0);
            #1 chk("seq_pc", 32'(Fpc), 32'(i));
        end
        go(16'h5004, 0);
        step(0, 0, {6'h30, 12'h123}, 0, 0, 0, 0, 0);
        #1 chk("jmp_pc", 32'(Fpc), 32'h5123);
        step(1, 0, NOP, 0, 0, 0, 0, 0);
        go(16'h0010, 0);
        step(0, 0, {6'h31, 8'h00, 4'hE}, 0, 0, 0, 0, 0);
        #1 chk("beq_nt_pc", 32'(Fpc), 32'h0011);
        go(16'h0010, 0);
        step(0, 1, {6'h31, 8'h00, 4'hE}, 1, 3'(BR_IDX), 1, 0, 0);
        step(0, 1, {6'h31, 8'h00, 4'hE}, 1, 3'(BR_IDX), 1, 0, 0);
        #1 chk("beq_t_pred", 32'(Fpredict_taken), 1);
        step(0, 0, {6'h31, 8'h00, 4'hE}, 0, 0, 0, 0, 0);
        #1 chk("beq_t_pc", 32'(Fpc), 32'h000F);
        go(16'h0040, 0);
        step(0, 1, NOP, 0, 0, 0, 0, 0);
        step(0, 1, NOP, 1, 3'd5, 0, 1, 16'h0100);
        step(0, 1, NOP, 0, 0, 0, 0, 0);
        #1 chk("stall_redir_pc", 32'(Fpc), 32'h0100);
        step(1, 0, NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, NOP, 1, 3'd2, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, NOP, 1, 3'd2, 1, 0, 0);
        step(1, 0, NOP, 0, 0, 0, 0, 0);
        go(16'h0007, 1);
        step(0, 1, NOP, 1, 3'd0, 0, 0, 0);
        step(0, 1, NOP, 1, 3'd0, 1, 0, 0);
        #1 chk("ghr_xorout", 32'(xorout), 32'(XOR_EXP));
        go(16'hFFFF, 0);
        step(0, 0, NOP, 0, 0, 0, 0, 0);
        #1 chk("wrap_pc", 32'(Fpc), 0);
        go(16'h0033, 1);
        step(1, 0, NOP, 1, 3'd0, 1, 1, 16'h1234);
        #1 chk("rst_redir_pc", 32'(Fpc), 0);
        step(0, 1, {6'h31, 12'h000}, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            data = {ops[$urandom_range(0, 3)], 12'($urandom)};
            if (data[17:12] == 6'h00) data[17:12] = 6'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, data,
                 $urandom_range(0, 2) == 0, 3'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0 ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
